// File: rtl/recorder_pkg.sv
// Shared types and helpers for the BRAM sample recorder.
package recorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } rec_state_t;

    localparam logic [31:0] BRAM_ADDR_INCREMENT = 32'd4;
    localparam logic [3:0]  BRAM_WE_ALL         = 4'hF;

    function automatic logic [31:0] sign_extend(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO; read data is the head entry, consumed on pop.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = count_q == CNT_W'(DEPTH);
    assign empty    = count_q == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/bram_sample_recorder.sv
// Records a fixed-length clip of 16-bit samples into BRAM as sign-extended
// 32-bit words, buffering through a small FIFO while the PS holds the BRAM.
module bram_sample_recorder
    import recorder_pkg::*;
#(
    parameter int          NUM_WORDS  = 256,
    parameter int          CLIP_LEN   = NUM_WORDS,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] BRAM_addr,
    output logic        BRAM_clk,
    output logic [31:0] BRAM_din,
    input  logic [31:0] BRAM_dout,
    output logic        BRAM_en,
    output logic        BRAM_rst,
    output logic [3:0]  BRAM_we,
    input  logic        arm,
    input  logic        bram_hold,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    output logic        sample_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] words_written
);
    localparam int CLIP_WORDS = (CLIP_LEN > NUM_WORDS) ? NUM_WORDS : CLIP_LEN;
    localparam logic [15:0] CLIP_LAST = 16'(CLIP_WORDS - 1);

    rec_state_t  state_q, state_d;
    logic [15:0] accepted_q, accepted_d;
    logic [15:0] words_q, words_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        overflow_q, overflow_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        brst_q;

    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [15:0] fifo_data;
    logic        capturing, writing;
    logic        unused_dout;

    assign unused_dout  = ^BRAM_dout;
    assign capturing    = state_q == ST_CAPTURE;
    assign writing      = capturing || (state_q == ST_DRAIN);
    assign sample_ready = capturing && !fifo_full;
    assign fifo_push    = sample_valid && sample_ready;
    assign fifo_pop     = writing && !fifo_empty && !bram_hold;

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sample_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        accepted_d = accepted_q;
        words_d    = words_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        en_d       = 1'b0;
        we_d       = '0;
        addr_d     = addr_q;
        din_d      = din_q;

        if (fifo_push) accepted_d = accepted_q + 16'd1;
        if (capturing && sample_valid && !sample_ready) overflow_d = 1'b1;

        if (fifo_pop) begin
            en_d    = 1'b1;
            we_d    = BRAM_WE_ALL;
            addr_d  = BASE_ADDR + 32'(words_q) * BRAM_ADDR_INCREMENT;
            din_d   = sign_extend(fifo_data);
            words_d = words_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d    = ST_CAPTURE;
                    accepted_d = '0;
                    words_d    = '0;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (fifo_push && accepted_q == CLIP_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_pop && words_q == CLIP_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CAPTURE) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            accepted_q <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= '0;
            addr_q     <= BASE_ADDR;
            din_q      <= '0;
            brst_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            accepted_q <= accepted_d;
            words_q    <= words_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            brst_q     <= 1'b0;
        end
    end

    assign BRAM_clk      = clk;
    assign BRAM_addr     = addr_q;
    assign BRAM_din      = din_q;
    assign BRAM_en       = en_q;
    assign BRAM_we       = we_q;
    assign BRAM_rst      = brst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_bram_sample_recorder.sv
// Self-checking bench for bram_sample_recorder against a clip-level
// reference model (counts, sample queue, expected BRAM contents).
module tb_bram_sample_recorder;
    localparam int          NWORDS = 8;
    localparam int          CLIP   = 8;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] BRAM_addr, BRAM_din, BRAM_dout;
    logic        BRAM_clk, BRAM_en, BRAM_rst;
    logic [3:0]  BRAM_we;
    logic        arm, bram_hold, sample_valid;
    logic [15:0] sample_in;
    logic        sample_ready, busy, done, overflow;
    logic [15:0] words_written;

    int n_checks = 0;
    int n_err    = 0;
    int act_writes = 0;
    int exp_writes = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
    } wr_t;
    wr_t wlog[$];

    bit          m_armed, m_ovf, m_en, m_brst;
    int          m_acc, m_wr;
    logic [15:0] m_fifo[$];
    logic [31:0] m_addr, m_din;

    always #5 clk = ~clk;

    bram_sample_recorder #(
        .NUM_WORDS  (NWORDS),
        .CLIP_LEN   (CLIP),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .BRAM_addr     (BRAM_addr),
        .BRAM_clk      (BRAM_clk),
        .BRAM_din      (BRAM_din),
        .BRAM_dout     (BRAM_dout),
        .BRAM_en       (BRAM_en),
        .BRAM_rst      (BRAM_rst),
        .BRAM_we       (BRAM_we),
        .arm           (arm),
        .bram_hold     (bram_hold),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .sample_ready  (sample_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_armed = 0;
        m_ovf   = 0;
        m_en    = 0;
        m_brst  = 1;
        m_acc   = 0;
        m_wr    = 0;
        m_fifo.delete();
        m_addr  = BASE;
        m_din   = '0;
    endfunction

    // One clock edge of the clip-level behaviour.
    function automatic void model_edge(bit a, bit v, logic [15:0] d, bit h);
        bit cap = m_armed && m_acc < CLIP;
        bit act = m_armed && m_wr < CLIP;
        bit rdy = cap && m_fifo.size() < DEPTH;
        bit pop = act && m_fifo.size() > 0 && !h;
        logic [15:0] s;
        m_brst = 0;
        m_en   = pop;
        if (pop) begin
            s      = m_fifo.pop_front();
            m_addr = BASE + 32'(m_wr * 4);
            m_din  = 32'(int'(shortint'(s)));
            m_wr++;
            exp_writes++;
        end
        if (v && rdy) begin
            m_fifo.push_back(d);
            m_acc++;
        end else if (v && cap) begin
            m_ovf = 1;
        end
        if (a && !act) begin
            m_armed = 1;
            m_acc   = 0;
            m_wr    = 0;
            m_ovf   = 0;
        end
    endfunction

    task automatic check_all();
        bit rdy_exp = m_armed && m_acc < CLIP && m_fifo.size() < DEPTH;
        if (BRAM_en === 1'b1) begin
            act_writes++;
            wlog.push_back('{BRAM_addr, BRAM_din});
        end
        chk("bram_en", 32'(BRAM_en), 32'(m_en));
        chk("bram_we", 32'(BRAM_we), m_en ? 32'hF : 32'h0);
        chk("bram_addr", BRAM_addr, m_addr);
        chk("bram_din", BRAM_din, m_din);
        chk("bram_rst", 32'(BRAM_rst), 32'(m_brst));
        chk("sample_ready", 32'(sample_ready), 32'(rdy_exp));
        chk("busy", 32'(busy), 32'(m_armed && m_wr < CLIP));
        chk("done", 32'(done), 32'(m_armed && m_wr == CLIP));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("words_written", 32'(words_written), 32'(m_wr));
    endtask

    task automatic cycle(input bit a, input bit v, input logic [15:0] d,
                         input bit h);
        arm          = a;
        sample_valid = v;
        sample_in    = d;
        bram_hold    = h;
        @(posedge clk);
        model_edge(a, v, d, h);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_until_done();
        for (int i = 0; i < 100 && !(m_armed && m_wr == CLIP); i++)
            cycle(0, 1, 16'($urandom), 0);
        chk("clip_done", 32'(done), 32'h1);
    endtask

    initial begin
        int base_idx;
        logic [31:0] exp_din [4];
        exp_din[0] = 32'h00000001;
        exp_din[1] = 32'hFFFFFFFF;
        exp_din[2] = 32'h00007FFF;
        exp_din[3] = 32'hFFFF8000;

        model_reset();
        BRAM_dout    = '0;
        arm          = 0;
        sample_valid = 0;
        sample_in    = '0;
        bram_hold    = 0;
        repeat (2) @(negedge clk);
        check_all();
        chk("bram_clk", 32'(BRAM_clk), 32'(clk));
        rst = 0;
        cycle(0, 0, '0, 0);

        // strobes while idle are ignored
        repeat (3) cycle(0, 1, 16'($urandom), 0);

        cycle(1, 0, '0, 0);
        cycle(0, 1, 16'h0001, 0);
        cycle(0, 1, 16'hFFFF, 0);
        cycle(0, 1, 16'h7FFF, 0);
        cycle(1, 1, 16'h8000, 0);
        repeat (4) cycle(0, 1, 16'($urandom), 0);
        run_until_done();
        chk("clip1_writes", 32'(wlog.size()), 32'(CLIP));
        if (wlog.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("clip1_addr", wlog[i].addr, BASE + 32'(4 * i));
                chk("clip1_din", wlog[i].din, exp_din[i]);
            end
        end
        chk("clip1_last_addr", BRAM_addr, BASE + 32'(4 * (CLIP - 1)));

        // strobes while done are ignored
        repeat (3) cycle(0, 1, 16'($urandom), 0);

        // hold while the source keeps streaming
        base_idx = wlog.size();
        cycle(1, 0, '0, 0);
        repeat (8) cycle(0, 1, 16'($urandom), 1);
        chk("hold_overflow", 32'(overflow), 32'h1);
        chk("hold_ready", 32'(sample_ready), 32'h0);
        chk("hold_no_write", 32'(wlog.size() - base_idx), 32'h0);
        run_until_done();
        for (int i = base_idx; i < wlog.size(); i++)
            chk("hold_addr", wlog[i].addr, BASE + 32'(4 * (i - base_idx)));

        repeat (3) begin
            cycle(1, 0, '0, 0);
            repeat (30)
                cycle(0, $urandom_range(9, 0) < 7, 16'($urandom),
                      $urandom_range(3, 0) == 0);
            run_until_done();
        end

        // async reset in the middle of a clip
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 20 && m_wr < 3; i++)
            cycle(0, 1, 16'($urandom), 0);
        chk("pre_rst_en", 32'(BRAM_en), 32'h1);
        #1 rst = 1;
        #1;
        chk("async_en", 32'(BRAM_en), 32'h0);
        chk("async_we", 32'(BRAM_we), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_bram_rst", 32'(BRAM_rst), 32'h1);
        chk("async_addr", BRAM_addr, BASE);
        chk("async_ww", 32'(words_written), 32'h0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 0;
        repeat (5) cycle(0, 1, 16'($urandom), 0);
        cycle(1, 0, '0, 0);
        run_until_done();

        chk("total_writes", 32'(act_writes), 32'(exp_writes));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
